// File: rtl/pim_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pim_pkg                                                              |
// | Shared types and helpers for the bit-serial PIM matrix-vector engine |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pim_pkg;

  localparam int SAT_W = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_t;

  function automatic int clogb2(input int value);
    int width = 0;
    for (int v = value - 1; v > 0; v = v >> 1) width++;
    return (width < 1) ? 1 : width;
  endfunction

  function automatic int acc_width(input int adc_p, input int input_p);
    return adc_p + input_p + input_p / 2 + 2;
  endfunction

  function automatic logic is_sat(input logic [SAT_W-1:0] acc, input int out_p);
    return (acc >> out_p) != '0;
  endfunction

  // Clips to all ones when the value does not fit in out_p bits.
  function automatic logic [SAT_W-1:0] sat_trunc(input logic [SAT_W-1:0] acc, input int out_p);
    logic [SAT_W-1:0] mask;
    mask = (SAT_W'(1) << out_p) - SAT_W'(1);
    return is_sat(acc, out_p) ? mask : (acc & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pim_shift_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pim_shift_acc                                                        |
// | Combines four ADC partial products and shift-accumulates bit-planes  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pim_shift_acc
  import pim_pkg::*;
#(
  parameter int ADC_P   = 8,
  parameter int INPUT_P = 16,
  parameter int ACC_W   = acc_width(ADC_P, INPUT_P)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_acc_en,
  input  logic [ADC_P-1:0] i_adc_hh,
  input  logic [ADC_P-1:0] i_adc_hl,
  input  logic [ADC_P-1:0] i_adc_lh,
  input  logic [ADC_P-1:0] i_adc_ll,
  output logic [ACC_W-1:0] o_acc_next
);

  localparam int K = INPUT_P / 2;

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_term;

  always_comb begin
    w_term = (ACC_W'(i_adc_hh) << INPUT_P)
           + ((ACC_W'(i_adc_hl) + ACC_W'(i_adc_lh)) << K)
           + ACC_W'(i_adc_ll);
    if (i_clear)
      o_acc_next = '0;
    else if (i_acc_en)
      o_acc_next = (r_acc << 1) + w_term;
    else
      o_acc_next = r_acc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_acc <= '0;
    else      r_acc <= o_acc_next;
  end

endmodule
`default_nettype wire

// File: rtl/pim_bitserial_mvm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pim_bitserial_mvm                                                    |
// | Bit-serial MVM sequencer driving a PIM crossbar over a row range     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pim_bitserial_mvm
  import pim_pkg::*;
#(
  parameter int INPUT_SIZE = 100,
  parameter int INPUT_P    = 16,
  parameter int DEPTH      = 100,
  parameter int ADC_P      = 8,
  parameter int OUT_P      = 16,
  parameter int ADDR_W     = clogb2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             start_addr,
  input  logic [ADDR_W-1:0]             end_addr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INPUT_SIZE*INPUT_P-1:0] in_data,
  output logic                          xb_en,
  output logic [ADDR_W-1:0]             xb_addr,
  output logic [INPUT_SIZE-1:0]         xb_bits_h,
  output logic [INPUT_SIZE-1:0]         xb_bits_l,
  input  logic [ADC_P-1:0]              xb_adc_hh,
  input  logic [ADC_P-1:0]              xb_adc_hl,
  input  logic [ADC_P-1:0]              xb_adc_lh,
  input  logic [ADC_P-1:0]              xb_adc_ll,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_P-1:0]              out_data,
  output logic [ADDR_W-1:0]             out_addr,
  output logic                          out_sat,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
);

  localparam int K     = INPUT_P / 2;
  localparam int BIT_W = clogb2(K);
  localparam int ACC_W = acc_width(ADC_P, INPUT_P);

  state_t                        r_state;
  logic [ADDR_W-1:0]             r_row;
  logic [ADDR_W-1:0]             r_end;
  logic [BIT_W-1:0]              r_bit;
  logic [INPUT_SIZE*INPUT_P-1:0] r_vec;
  logic                          r_ret;

  logic [INPUT_SIZE*INPUT_P-1:0] w_src;
  logic [BIT_W-1:0]              w_sel_plane;
  logic [INPUT_SIZE-1:0]         w_plane_h;
  logic [INPUT_SIZE-1:0]         w_plane_l;
  logic [ADDR_W-1:0]             w_row_next;
  logic                          w_clear;
  logic [ACC_W-1:0]              w_acc_next;

  assign in_ready = (r_state == LOAD);

  // The first plane of a fresh vector is taken straight from in_data, since
  // it is issued on the same edge that latches the vector.
  always_comb begin
    w_src       = (r_state == LOAD) ? in_data : r_vec;
    w_sel_plane = (r_state == ISSUE) ? (r_bit - BIT_W'(1)) : BIT_W'(K - 1);
    w_row_next  = (r_row == ADDR_W'(DEPTH - 1)) ? '0 : (r_row + ADDR_W'(1));
    w_clear     = ((r_state == LOAD) && in_valid)
               || ((r_state == OUT) && out_ready && !out_last);
  end

  for (genvar gi = 0; gi < INPUT_SIZE; gi++) begin : g_plane
    logic [INPUT_P-1:0] w_elem;
    logic [K-1:0]       w_hi;
    logic [K-1:0]       w_lo;
    assign w_elem        = w_src[gi*INPUT_P +: INPUT_P];
    assign w_hi          = w_elem[INPUT_P-1:K];
    assign w_lo          = w_elem[K-1:0];
    assign w_plane_h[gi] = w_hi[w_sel_plane];
    assign w_plane_l[gi] = w_lo[w_sel_plane];
  end

  pim_shift_acc #(
    .ADC_P  (ADC_P),
    .INPUT_P(INPUT_P),
    .ACC_W  (ACC_W)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_acc_en  (r_ret),
    .i_adc_hh  (xb_adc_hh),
    .i_adc_hl  (xb_adc_hl),
    .i_adc_lh  (xb_adc_lh),
    .i_adc_ll  (xb_adc_ll),
    .o_acc_next(w_acc_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_row     <= '0;
      r_end     <= '0;
      r_bit     <= '0;
      r_vec     <= '0;
      r_ret     <= 1'b0;
      xb_en     <= 1'b0;
      xb_addr   <= '0;
      xb_bits_h <= '0;
      xb_bits_l <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_sat   <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_ret <= xb_en;
      done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_row   <= start_addr;
            r_end   <= end_addr;
            busy    <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            r_vec     <= in_data;
            xb_en     <= 1'b1;
            xb_addr   <= r_row;
            xb_bits_h <= w_plane_h;
            xb_bits_l <= w_plane_l;
            r_bit     <= BIT_W'(K - 1);
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_bit == '0) begin
            xb_en   <= 1'b0;
            r_state <= DRAIN;
          end else begin
            xb_bits_h <= w_plane_h;
            xb_bits_l <= w_plane_l;
            r_bit     <= w_sel_plane;
          end
        end
        DRAIN: begin
          out_valid <= 1'b1;
          out_data  <= OUT_P'(sat_trunc(SAT_W'(w_acc_next), OUT_P));
          out_sat   <= is_sat(SAT_W'(w_acc_next), OUT_P);
          out_addr  <= r_row;
          out_last  <= (r_row == r_end);
          r_state   <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_row     <= w_row_next;
              xb_en     <= 1'b1;
              xb_addr   <= w_row_next;
              xb_bits_h <= w_plane_h;
              xb_bits_l <= w_plane_l;
              r_bit     <= BIT_W'(K - 1);
              r_state   <= ISSUE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/pim_bitserial_mvm.md
# pim_bitserial_mvm

Parametrised bit-serial matrix-vector engine that drives a PIM crossbar macro over a programmable row range. It latches one input vector through a valid/ready handshake. For each crossbar row address it streams the vector's high and low nibbles MSB-first as bit-planes and shift-accumulates the four ADC partial products (HH, HL, LH, LL) into a full-precision dot product. Each row's result is emitted on a backpressured output stream. It sits between the vector SRAM and the GEMM top-level, replacing single-address, free-running PIM wrappers.

## Interface
- INPUT_SIZE, 100: vector elements (crossbar rows driven per bit-plane)
- INPUT_P, 16: element precision, even; weights share this precision
- DEPTH, 100: crossbar columns (addressable result rows)
- ADC_P, 8: ADC output width
- OUT_P, 16: output width
- ADDR_W, clogb2(DEPTH): row address width
- ACC_W, ADC_P+INPUT_P+INPUT_P/2+2: accumulator width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- start_addr, end_addr  in  ADDR_W  inclusive row range
- in_valid / in_ready  in / out  1  vector handshake
- in_data  in  INPUT_SIZE*INPUT_P  element i at [i*INPUT_P +: INPUT_P]
- xb_en  out  1  crossbar evaluate strobe
- xb_addr  out  ADDR_W  crossbar column
- xb_bits_h, xb_bits_l  out  INPUT_SIZE  current bit-plane of high/low nibbles
- xb_adc_hh, xb_adc_hl, xb_adc_lh, xb_adc_ll  in  ADC_P  each; valid exactly 1 cycle after xb_en
- out_valid / out_ready  out / in  1  result handshake
- out_data  out  OUT_P  saturated result
- out_addr  out  ADDR_W  row of out_data
- out_sat  out  1  result was clipped
- out_last  out  1  result belongs to end_addr
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse after the last result handshake

## Operation
- States:
  - IDLE: start → LOAD; row ← start_addr.
  - LOAD: in_ready=1; on in_valid, latch vector → ISSUE.
  - ISSUE: K = INPUT_P/2 cycles; bit k issued MSB-first. The cycle after the last issue → DRAIN.
  - DRAIN: one cycle; accumulates the last ADC return → OUT.
  - OUT: out_valid=1. On out_ready, if row==end_addr → IDLE with done; else row advances → ISSUE. The same vector is reused.
- Row advance: row+1, wrapping DEPTH-1→0. If start_addr>end_addr, the sequence wraps (e.g. 6,7,0,1). start_addr==end_addr yields one row.
- Nibbles: xH = elem[INPUT_P-1:INPUT_P/2], xL = elem[INPUT_P/2-1:0]. xb_bits_h[i] = xH_i[K-1-k].
- Per-return term: (hh<<INPUT_P) + ((hl+lh)<<K) + ll.
- Accumulation: acc ← (acc<<1) + term. acc clears when a row enters ISSUE.
- Output: acc unsigned; if acc ≥ 2^OUT_P then out_data = all ones and out_sat=1, else truncated. All arithmetic is unsigned; no intermediate overflow within ACC_W.
- start while busy is ignored. ADC inputs outside return cycles are ignored.
- Reset: all state → IDLE; outputs xb_en, in_ready, out_valid, out_sat, out_last, busy, done = 0; xb_addr, xb_bits_*, out_data, out_addr = 0. Reset mid-row discards the accumulator and vector; no output is produced.

## Timing
- Relative to the vector handshake cycle T: first xb_en at T+1, last issue at T+K, first out_valid at T+K+2.
- Per row, without backpressure: K+2 cycles (issue K, drain 1, out 1).
- xb_addr and xb_bits_* are stable while xb_en is high and change only on issue cycles.
- out_data, out_addr, out_sat, out_last hold while out_valid && !out_ready. No xb_en during OUT.
- done asserts the cycle after the final handshake; busy falls the same cycle.
- in_ready is high only in LOAD and is combinational from state only.

## Structure
- Shared package pim_pkg:
  - clogb2
  - state enum {IDLE, LOAD, ISSUE, DRAIN, OUT}
  - ACC_W derivation function
  - saturating-truncate function
- Sub-module pim_shift_acc: clear, accumulate enable, four ADC inputs → acc. Holds the term adder and shift register.
- Top level holds the FSM, row/bit counters, vector register, bit-plane muxes and output register.

## Test plan
Bench parameters: INPUT_SIZE=4, INPUT_P=8, DEPTH=8, ADC_P=4, OUT_P=16. The crossbar model returns programmed ADC values one cycle after xb_en.
- ADC constant hh=hl=lh=ll=1, range 3..3 → one result, out_data=4335 (289·15), out_sat=0, out_last=1, done pulse; out_valid exactly 6 cycles after the in handshake.
- Same stimulus with OUT_P=12 → out_data=4095, out_sat=1.
- in_data element0=8'hA5, others 0; observe xb_bits_h sequence 1,0,1,0 and xb_bits_l sequence 0,1,0,1 on bit 0 across the 4 issue cycles.
- Range start=6, end=1 → out_addr 6,7,0,1; out_last only on 1; exactly 4 results, one in handshake.
- out_ready low 5 cycles on row 2 → out_* stable, xb_en low, then the sequence resumes with no lost or duplicated row.
- rst asserted during the ISSUE of row 1 → all outputs reset value the next edge; a fresh start completes normally; start pulsed while busy is ignored.
